dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the `dualportram` between NUM_REQ requesters (e.g. instruction fetch, load/store, debug).
- Each requester sees a RAM-like req/gnt/rvalid interface.
- The arbiter drives one RAM port: req/we/be/addr/wdata in, rvalid/rdata out.
- It tracks the owner of the in-flight access, routes the response back to that owner, and terminates out-of-range accesses locally with an error response.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- RAM_SIZE, 8192, RAM size in bytes; addresses >= RAM_SIZE are out of range.
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- req_i  in  NUM_REQ  per-requester request.
- we_i  in  NUM_REQ  per-requester write enable.
- be_i  in  NUM_REQ x DW/8  per-requester byte enables.
- addr_i  in  NUM_REQ x AW  per-requester byte address.
- wdata_i  in  NUM_REQ x DW  per-requester write data.
- gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted req.
- rvalid_o  out  NUM_REQ  one-hot response valid, one cycle after grant.
- err_o  out  NUM_REQ  response is an error; qualified by rvalid_o.
- rdata_o  out  DW  response data, shared by all requesters; qualified by rvalid_o.
- mem_req_o  out  1  RAM port request.
- mem_we_o  out  1  RAM port write enable.
- mem_be_o  out  DW/8  RAM port byte enables.
- mem_addr_o  out  AW  RAM port address.
- mem_wdata_o  out  DW  RAM port write data.
- mem_rvalid_i  in  1  RAM response valid; arrives one cycle after every accepted mem_req_o.
- mem_rdata_i  in  DW  RAM read data.

Behaviour:
- **Requester contract:**
  - A requester holds req/we/be/addr/wdata stable until it sees gnt_o high at a rising edge.
  - It may drop req only after grant.
  - At most one grant per cycle. The arbiter accepts a new request every cycle; responses are in order, one cycle after grant.
- **Arbitration:**
  - Round-robin pointer ptr_q.
  - Winner is the first asserted req_i scanning indices ptr_q, ptr_q+1, ... modulo NUM_REQ.
  - On any grant to index k, ptr_q <= (k+1) mod NUM_REQ.
  - With no requests, ptr_q holds.
- **In-range forwarding:**
  - When addr of the winner < RAM_SIZE: mem_req_o=1 and mem_* is muxed from the winner, combinationally, same cycle.
  - Registered: owner_q <= k, pend_q <= 1, err_q <= 0.
- **Out-of-range termination:**
  - When addr of the winner >= RAM_SIZE: the requester is still granted and mem_req_o=0 (no RAM access, writes dropped).
  - Registered: owner_q <= k, pend_q <= 1, err_q <= 1.
- **Response cycle (pend_q=1):**
  - rvalid_o[owner_q] = err_q ? 1 : mem_rvalid_i.
  - err_o[owner_q] = err_q.
  - rdata_o = err_q ? 0 : mem_rdata_i.
  - Responses are issued for writes as well as reads.
- **No grant in a cycle:** pend_q <= 0.
- **Response outside a pending cycle:** mem_rvalid_i while pend_q=0 is ignored; no rvalid_o.
- **Idle mem outputs:** when mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
- **Reset (rst_n_i=0 at a rising edge):**
  - ptr_q=0, owner_q=0, pend_q=0, err_q=0.
  - While rst_n_i=0: gnt_o=0, mem_req_o=0, rvalid_o=0, err_o=0, rdata_o=0.
  - Reset mid-operation drops any pending response.
- **Boundary cases:**
  - addr = RAM_SIZE-4 is in range; addr = RAM_SIZE is an error.
  - NUM_REQ not a power of two: the pointer wraps from NUM_REQ-1 to 0.
  - A single continuous requester is granted every cycle.

Decomposition:
- Package `dpram_arb_pkg`: typedef req_t (we, be, addr, wdata) and rsp_t (rvalid, err, rdata), constant BE_W = DW/8, function in_range(addr, RAM_SIZE).
- One sub-module: `rr_arbiter` (NUM_REQ; inputs req vector and enable; outputs one-hot gnt; owns ptr_q and its update). The top instantiates it and adds the mux, range check and response routing.

Test Plan:
- Reset, then req_i=3'b001, write addr 0x0 data 0xDEADBEEF be 4'b1111 → gnt_o=001 same cycle, mem_req_o=1, mem_addr_o=0; next cycle rvalid_o=001, err_o=0. A read of 0x0 then returns rdata_o=0xDEADBEEF at rvalid_o=001.
- req_i=3'b111 held continuously with every grant accepted → grants 001, 010, 100, 001 on consecutive cycles; each rvalid_o equals the previous cycle's gnt_o.
- Requester 2 writes 0x10 = 0x11112222; requesters 0 and 1 then read 0x10 in the same cycle → requester 0 granted first, requester 1 next cycle; both receive 0x11112222 on consecutive cycles, each routed to the correct index.
- Requester 1 reads addr 0x2000 (RAM_SIZE=8192) → gnt_o=010, mem_req_o=0; next cycle rvalid_o=010, err_o=010, rdata_o=0. A read at 0x1FFC → err_o=0.
- Byte-enable passthrough: requester 0 writes 0x30=0xFFFFFFFF be 0011, requester 2 writes 0x30=0xAAAA0000 be 1100, then a read of 0x30 → 0xAAAAFFFF.
- Grant to requester 1, then rst_n_i=0 on the following cycle with mem_rvalid_i=1 → rvalid_o=0. After release, req_i=3'b111 → first grant is 001 (ptr reset to 0).

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter.
//   req_t    : one requester's access (we, be, addr, wdata)
//   rsp_t    : response returned to the owning requester (rvalid, err, rdata)
//   in_range : true when a byte address falls inside the RAM
package dpram_arb_pkg;

   localparam int ARB_AW = 32;
   localparam int ARB_DW = 32;
   localparam int BE_W   = ARB_DW / 8;

   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ARB_AW-1:0] addr;
      logic [ARB_DW-1:0] wdata;
   } req_t;

   typedef struct packed {
      logic              rvalid;
      logic              err;
      logic [ARB_DW-1:0] rdata;
   } rsp_t;

   function automatic logic in_range(input logic [ARB_AW-1:0] addr,
                                     input logic [ARB_AW-1:0] ram_size);
      return addr < ram_size;
   endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   en        : grant enable (grants forced low when 0)
//   req       : request vector
//   gnt       : one-hot grant, combinational
//   gnt_valid : some requester was granted this cycle
//   gnt_idx   : index of the granted requester
module rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [PTR_W-1:0]   gnt_idx
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W:0]   sum;

   // Scan ptr_q, ptr_q+1, ... and take the first asserted request. The extra
   // bit on sum lets the wrap work for non-power-of-two NUM_REQ.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      sum       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(NUM_REQ))
            sum = sum - (PTR_W+1)'(NUM_REQ);
         if (en && !gnt_valid && req[sum[PTR_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = sum[PTR_W-1:0];
         end
      end
      gnt = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr_q <= '0;
      else if (gnt_valid)
         ptr_q <= (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one RAM port between NUM_REQ requesters with round-robin priority.
// Accesses outside the RAM are granted but terminated locally with an error.
//   clk_i, rst_n_i                      : clock, synchronous active-low reset
//   req_i/we_i/be_i/addr_i/wdata_i      : per-requester request
//   gnt_o                               : one-hot grant (combinational)
//   rvalid_o/err_o                      : one-hot response to the owner
//   rdata_o                             : shared response data
//   mem_req_o/we/be/addr/wdata          : RAM port, zero when idle
//   mem_rvalid_i/mem_rdata_i            : RAM response, one cycle after req
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int          NUM_REQ  = 3,
   parameter int unsigned RAM_SIZE = 8192,
   parameter int          AW       = ARB_AW,
   parameter int          DW       = ARB_DW,
   localparam int         PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk_i,
   input  logic                            rst_n_i,
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ-1:0]              we_i,
   input  logic [NUM_REQ-1:0][DW/8-1:0]    be_i,
   input  logic [NUM_REQ-1:0][AW-1:0]      addr_i,
   input  logic [NUM_REQ-1:0][DW-1:0]      wdata_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   output logic [NUM_REQ-1:0]              rvalid_o,
   output logic [NUM_REQ-1:0]              err_o,
   output logic [DW-1:0]                   rdata_o,
   output logic                            mem_req_o,
   output logic                            mem_we_o,
   output logic [DW/8-1:0]                 mem_be_o,
   output logic [AW-1:0]                   mem_addr_o,
   output logic [DW-1:0]                   mem_wdata_o,
   input  logic                            mem_rvalid_i,
   input  logic [DW-1:0]                   mem_rdata_i
);

   logic             gnt_valid;
   logic [PTR_W-1:0] gnt_idx;
   req_t             sel;
   rsp_t             rsp;
   logic             win_in_range;
   logic             mem_fwd;

   logic [PTR_W-1:0] owner_q;
   logic             pend_q;
   logic             err_q;

   // Gating the arbiter with reset keeps grants and RAM requests low while
   // rst_n_i is held, not just after the first reset edge.
   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .en        (rst_n_i),
      .req       (req_i),
      .gnt       (gnt_o),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      sel.we       = we_i[gnt_idx];
      sel.be       = be_i[gnt_idx];
      sel.addr     = addr_i[gnt_idx];
      sel.wdata    = wdata_i[gnt_idx];
      win_in_range = in_range(sel.addr, ARB_AW'(RAM_SIZE));
      mem_fwd      = gnt_valid && win_in_range;

      mem_req_o    = mem_fwd;
      mem_we_o     = mem_fwd && sel.we;
      mem_be_o     = mem_fwd ? sel.be    : '0;
      mem_addr_o   = mem_fwd ? sel.addr  : '0;
      mem_wdata_o  = mem_fwd ? sel.wdata : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         owner_q <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (gnt_valid) begin
         owner_q <= gnt_idx;
         pend_q  <= 1'b1;
         err_q   <= !win_in_range;
      end else begin
         pend_q  <= 1'b0;
      end
   end

   // Error responses complete on their own; RAM responses are only honoured
   // while an access is pending, so stray mem_rvalid_i is dropped.
   always_comb begin
      rsp.rvalid = rst_n_i && pend_q && (err_q || mem_rvalid_i);
      rsp.err    = err_q;
      rsp.rdata  = (rst_n_i && pend_q && !err_q) ? mem_rdata_i : '0;

      rvalid_o = '0;
      err_o    = '0;
      if (rsp.rvalid) begin
         rvalid_o[owner_q] = 1'b1;
         err_o[owner_q]    = rsp.err;
      end
      rdata_o = rsp.rdata;
   end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [2:0]        req_i;
   logic [2:0]        we_i;
   logic [2:0][3:0]   be_i;
   logic [2:0][31:0]  addr_i;
   logic [2:0][31:0]  wdata_i;
   logic [2:0]        gnt_o;
   logic [2:0]        rvalid_o;
   logic [2:0]        err_o;
   logic [31:0]       rdata_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [3:0]        mem_be_o;
   logic [31:0]       mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_rvalid_i;
   logic [31:0]       mem_rdata_i;

   logic              ram_rvalid = 1'b0;
   logic [31:0]       ram_rdata  = 32'h0;
   logic              force_rv;
   logic [31:0]       ram [0:2047];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign mem_rvalid_i = ram_rvalid | force_rv;
   assign mem_rdata_i  = ram_rdata;

   dpram_port_arbiter dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_i        (req_i),
      .we_i         (we_i),
      .be_i         (be_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .err_o        (err_o),
      .rdata_o      (rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   // RAM behind the port: answers every accepted request one cycle later.
   always @(posedge clk) begin
      ram_rvalid <= mem_req_o;
      if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (mem_be_o[b]) ram[mem_addr_o[12:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
            ram_rdata <= 32'h0;
         end else begin
            ram_rdata <= ram[mem_addr_o[12:2]];
         end
      end
   end

   typedef struct {
      logic [2:0]  req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  gnt;
      logic        mreq;
      logic [2:0]  rvalid;
      logic [2:0]  err;
      logic        chk_rd;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(logic [2:0] req, logic we, logic [3:0] be, logic [31:0] addr,
                               logic [31:0] wdata, logic [2:0] gnt, logic mreq,
                               logic [2:0] rvalid, logic [2:0] err, logic chk_rd,
                               logic [31:0] rdata);
      vec_t v;
      v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
      v.gnt = gnt; v.mreq = mreq; v.rvalid = rvalid; v.err = err;
      v.chk_rd = chk_rd; v.rdata = rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_i   = req;
      we_i    = {3{we}};
      be_i    = {3{be}};
      addr_i  = {3{addr}};
      wdata_i = {3{wdata}};
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
      force_rv = 1'b0;
      rst_n    = 1'b0;
      drive(3'b111, 1'b0, 4'hF, 32'h0, 32'h0);

      // Held in reset with all requests active: nothing may leak out.
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_gnt",    32'(gnt_o),     32'h0);
      chk("rst_memreq", 32'(mem_req_o), 32'h0);
      chk("rst_rvalid", 32'(rvalid_o),  32'h0);
      chk("rst_rdata",  rdata_o,        32'h0);
      next_cycle();
      rst_n = 1'b1;
      drive(3'b000, 1'b0, 4'h0, 32'h0, 32'h0);
      next_cycle();

      //                 req     we    be     addr          wdata          gnt     mreq  rvalid  err     chk   rdata
      vecs[0]  = mk(3'b001, 1'b1, 4'hF, 32'h0000_0000, 32'hDEADBEEF, 3'b001, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0);
      vecs[1]  = mk(3'b001, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        3'b001, 1'b1, 3'b001, 3'b000, 1'b0, 32'h0);
      vecs[2]  = mk(3'b000, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        3'b000, 1'b0, 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
      vecs[3]  = mk(3'b100, 1'b0, 4'hF, 32'h0000_0004, 32'h0,        3'b100, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0);
      vecs[4]  = mk(3'b111, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        3'b001, 1'b1, 3'b100, 3'b000, 1'b0, 32'h0);
      vecs[5]  = mk(3'b111, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        3'b010, 1'b1, 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
      vecs[6]  = mk(3'b111, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        3'b100, 1'b1, 3'b010, 3'b000, 1'b1, 32'hDEADBEEF);
      vecs[7]  = mk(3'b111, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        3'b001, 1'b1, 3'b100, 3'b000, 1'b1, 32'hDEADBEEF);
      vecs[8]  = mk(3'b100, 1'b1, 4'hF, 32'h0000_0010, 32'h11112222, 3'b100, 1'b1, 3'b001, 3'b000, 1'b1, 32'hDEADBEEF);
      vecs[9]  = mk(3'b011, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        3'b001, 1'b1, 3'b100, 3'b000, 1'b0, 32'h0);
      vecs[10] = mk(3'b010, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        3'b010, 1'b1, 3'b001, 3'b000, 1'b1, 32'h11112222);
      vecs[11] = mk(3'b010, 1'b0, 4'hF, 32'h0000_2000, 32'h0,        3'b010, 1'b0, 3'b010, 3'b000, 1'b1, 32'h11112222);
      vecs[12] = mk(3'b010, 1'b0, 4'hF, 32'h0000_1FFC, 32'h0,        3'b010, 1'b1, 3'b010, 3'b010, 1'b1, 32'h0);
      vecs[13] = mk(3'b000, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        3'b000, 1'b0, 3'b010, 3'b000, 1'b1, 32'h0);
      vecs[14] = mk(3'b001, 1'b1, 4'h3, 32'h0000_0030, 32'hFFFFFFFF, 3'b001, 1'b1, 3'b000, 3'b000, 1'b0, 32'h0);
      vecs[15] = mk(3'b100, 1'b1, 4'hC, 32'h0000_0030, 32'hAAAA0000, 3'b100, 1'b1, 3'b001, 3'b000, 1'b0, 32'h0);
      vecs[16] = mk(3'b010, 1'b0, 4'hF, 32'h0000_0030, 32'h0,        3'b010, 1'b1, 3'b100, 3'b000, 1'b0, 32'h0);
      vecs[17] = mk(3'b000, 1'b0, 4'h0, 32'h0000_0000, 32'h0,        3'b000, 1'b0, 3'b010, 3'b000, 1'b1, 32'hAAAAFFFF);

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i),    32'(gnt_o),     32'(vecs[i].gnt));
         chk($sformatf("v%0d_memreq", i), 32'(mem_req_o), 32'(vecs[i].mreq));
         chk($sformatf("v%0d_memaddr", i), mem_addr_o,    vecs[i].mreq ? vecs[i].addr  : 32'h0);
         chk($sformatf("v%0d_memwdata", i), mem_wdata_o,  vecs[i].mreq ? vecs[i].wdata : 32'h0);
         chk($sformatf("v%0d_membe", i),  32'(mem_be_o),  vecs[i].mreq ? 32'(vecs[i].be) : 32'h0);
         chk($sformatf("v%0d_memwe", i),  32'(mem_we_o),  32'(vecs[i].mreq & vecs[i].we));
         chk($sformatf("v%0d_rvalid", i), 32'(rvalid_o),  32'(vecs[i].rvalid));
         chk($sformatf("v%0d_err", i),    32'(err_o),     32'(vecs[i].err));
         if (vecs[i].chk_rd)
            chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].rdata);
         next_cycle();
      end

      // Single continuous requester: granted every cycle.
      for (int i = 0; i < 4; i++) begin
         drive(3'b100, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
         @(negedge clk);
         chk($sformatf("solo%0d_gnt", i), 32'(gnt_o), 32'h4);
         if (i > 0) chk($sformatf("solo%0d_rvalid", i), 32'(rvalid_o), 32'h4);
         next_cycle();
      end
      drive(3'b000, 1'b0, 4'h0, 32'h0, 32'h0);
      next_cycle();

      // Grant to requester 1, then reset with a RAM response arriving.
      drive(3'b010, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
      @(negedge clk);
      chk("midrst_gnt", 32'(gnt_o), 32'h2);
      next_cycle();
      rst_n    = 1'b0;
      force_rv = 1'b1;
      drive(3'b111, 1'b0, 4'hF, 32'h0, 32'h0);
      @(negedge clk);
      chk("midrst_rvalid", 32'(rvalid_o),  32'h0);
      chk("midrst_rdata",  rdata_o,        32'h0);
      chk("midrst_gnt0",   32'(gnt_o),     32'h0);
      chk("midrst_memreq", 32'(mem_req_o), 32'h0);
      next_cycle();

      // Out of reset with a stray RAM response and no pending access.
      rst_n = 1'b1;
      drive(3'b000, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("stray_rvalid", 32'(rvalid_o), 32'h0);
      chk("stray_err",    32'(err_o),    32'h0);
      next_cycle();
      force_rv = 1'b0;

      // Pointer restarts at requester 0 after reset.
      drive(3'b111, 1'b0, 4'hF, 32'h0, 32'h0);
      @(negedge clk);
      chk("postrst_gnt", 32'(gnt_o), 32'h1);
      next_cycle();
      drive(3'b000, 1'b0, 4'h0, 32'h0, 32'h0);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
